// File: rtl/joy_dir_filter.sv
// Multi-player joystick conditioner: sync -> optional debounce (JOY_DEBOUNCE_EN)
// -> SOCD resolution -> optional 4-way restriction -> registered output.
module joy_dir_filter #(
  parameter int unsigned PLAYERS         = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk_sys,
  input  logic                   I_RESETn,
  input  logic [4*PLAYERS-1:0]   dir_in,
  input  logic [1:0]             socd_mode,
  input  logic                   way4,
  output logic [4*PLAYERS-1:0]   dir_out,
  output logic [PLAYERS-1:0]     dir_chg
);

  localparam int unsigned NB = 4 * PLAYERS;

  localparam logic [1:0] MODE_LAST    = 2'b00;
  localparam logic [1:0] MODE_NEUTRAL = 2'b01;
  localparam logic [1:0] MODE_FIRST   = 2'b10;

  logic [NB-1:0]      sync_q [SYNC_STAGES];
  logic [NB-1:0]      cond;
  logic [NB-1:0]      prev_q;
  logic [NB-1:0]      rise;

  logic [PLAYERS-1:0] last_v_q, last_v_d, last_h_q, last_h_d;
  logic [PLAYERS-1:0] own_v_q, own_v_d, own_h_q, own_h_d;
  logic [PLAYERS-1:0] axis_q, axis_d;
  logic [PLAYERS-1:0] nzv_q, nzv_d, nzh_q, nzh_d;
  logic [NB-1:0]      dir_q, dir_d;
  logic [PLAYERS-1:0] chg_q, chg_d;

  logic [PLAYERS-1:0][3:0] sv, sh;
  logic [PLAYERS-1:0][4:0] fw;

  // Input synchroniser chain, all bits in parallel
  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= dir_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef JOY_DEBOUNCE_EN
  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [NB-1:0] deb_q, deb_d;

  // Flip the debounced bit once the disagreement has lasted DEBOUNCE_CYCLES
  always_comb begin
    deb_d = deb_q;
    for (int unsigned b = 0; b < NB; b++) begin
      cnt_d[b] = '0;
      if (sync_q[SYNC_STAGES-1][b] != deb_q[b]) begin
        if (cnt_q[b] == CNT_TOP) deb_d[b] = ~deb_q[b];
        else                     cnt_d[b] = cnt_q[b] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      deb_q <= '0;
      for (int unsigned b = 0; b < NB; b++) cnt_q[b] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int unsigned b = 0; b < NB; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  assign cond = deb_q;
`else
  assign cond = sync_q[SYNC_STAGES-1];
`endif

  assign rise = cond & ~prev_q;

  // Per-axis SOCD; returns {out[1:0], last_next, owner_next}. Index 1 is U/L, 0 is D/R;
  // history bits hold 0 for U/L and 1 for D/R.
  function automatic logic [3:0] socd_axis(input logic [1:0] held, input logic [1:0] rs,
                                           input logic last_cur, input logic own_cur,
                                           input logic [1:0] mode);
    logic       last_n;
    logic       own_n;
    logic [1:0] res;
    last_n = last_cur;
    if (rs[1])      last_n = 1'b0;
    else if (rs[0]) last_n = 1'b1;
    own_n = own_cur;
    if (rs[1] && (rs[0] || !held[0])) own_n = 1'b0;
    else if (rs[0] && !held[1])       own_n = 1'b1;
    res = held;
    if (held == 2'b11) begin
      case (mode)
        MODE_LAST:    res = last_n ? 2'b01 : 2'b10;
        MODE_NEUTRAL: res = 2'b00;
        MODE_FIRST:   res = own_n ? 2'b01 : 2'b10;
        default:      res = held;
      endcase
    end
    return {res, last_n, own_n};
  endfunction

  // 4-way restriction; returns {out[3:0], axis_next} where axis 0 = V, 1 = H
  function automatic logic [4:0] four_way(input logic [3:0] o, input logic nzv_prev,
                                          input logic nzh_prev, input logic axis_cur,
                                          input logic w4);
    logic       v_nz, h_nz, v_new, h_new, axis_n;
    logic [3:0] res;
    v_nz   = |o[3:2];
    h_nz   = |o[1:0];
    v_new  = v_nz && !nzv_prev;
    h_new  = h_nz && !nzh_prev;
    axis_n = axis_cur;
    if (v_new && !h_new)      axis_n = 1'b0;
    else if (h_new && !v_new) axis_n = 1'b1;
    res = o;
    if (w4 && v_nz && h_nz) res = axis_n ? {2'b00, o[1:0]} : {o[3:2], 2'b00};
    return {res, axis_n};
  endfunction

  always_comb begin
    last_v_d = last_v_q;
    last_h_d = last_h_q;
    own_v_d  = own_v_q;
    own_h_d  = own_h_q;
    axis_d   = axis_q;
    nzv_d    = nzv_q;
    nzh_d    = nzh_q;
    dir_d    = dir_q;
    chg_d    = '0;
    sv       = '0;
    sh       = '0;
    fw       = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      sv[p] = socd_axis(cond[4*p+2 +: 2], rise[4*p+2 +: 2], last_v_q[p], own_v_q[p], socd_mode);
      sh[p] = socd_axis(cond[4*p +: 2], rise[4*p +: 2], last_h_q[p], own_h_q[p], socd_mode);
      last_v_d[p] = sv[p][1];
      own_v_d[p]  = sv[p][0];
      last_h_d[p] = sh[p][1];
      own_h_d[p]  = sh[p][0];
      nzv_d[p]    = |sv[p][3:2];
      nzh_d[p]    = |sh[p][3:2];
      fw[p]       = four_way({sv[p][3:2], sh[p][3:2]}, nzv_q[p], nzh_q[p], axis_q[p], way4);
      axis_d[p]   = fw[p][0];
      dir_d[4*p +: 4] = fw[p][4:1];
      chg_d[p]    = (fw[p][4:1] != dir_q[4*p +: 4]);
    end
  end

  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      prev_q   <= '0;
      last_v_q <= '0;
      last_h_q <= '0;
      own_v_q  <= '0;
      own_h_q  <= '0;
      axis_q   <= '0;
      nzv_q    <= '0;
      nzh_q    <= '0;
      dir_q    <= '0;
      chg_q    <= '0;
    end else begin
      prev_q   <= cond;
      last_v_q <= last_v_d;
      last_h_q <= last_h_d;
      own_v_q  <= own_v_d;
      own_h_q  <= own_h_d;
      axis_q   <= axis_d;
      nzv_q    <= nzv_d;
      nzh_q    <= nzh_d;
      dir_q    <= dir_d;
      chg_q    <= chg_d;
    end
  end

  assign dir_out = dir_q;
  assign dir_chg = chg_q;

endmodule

// File: tb/tb_joy_dir_filter.sv
// Scoreboard bench for joy_dir_filter (PLAYERS=2); debounce cases run when JOY_DEBOUNCE_EN is defined.
module tb_joy_dir_filter;

  localparam int unsigned PLAYERS = 2;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned DEB     = 16;
`ifdef JOY_DEBOUNCE_EN
  localparam int LAT = SYNC + 1 + DEB;
`else
  localparam int LAT = SYNC + 1;
`endif

  typedef struct {
    int         at;
    logic [7:0] dout;
    logic [1:0] chg;
  } exp_t;

  logic       clk_sys = 1'b0;
  logic       I_RESETn;
  logic [7:0] dir_in;
  logic [1:0] socd_mode;
  logic       way4;
  logic [7:0] dir_out;
  logic [1:0] dir_chg;

  int         cyc = 0;
  int         checks;
  int         errors;
  logic [7:0] exp_cur;
  exp_t       sb[$];

  joy_dir_filter #(
    .PLAYERS        (PLAYERS),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_sys  (clk_sys),
    .I_RESETn (I_RESETn),
    .dir_in   (dir_in),
    .socd_mode(socd_mode),
    .way4     (way4),
    .dir_out  (dir_out),
    .dir_chg  (dir_chg)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Drive raw directions; queue the hand-computed dir_out if it differs from the last one
  task automatic apply(input logic [7:0] din, input logic [7:0] exp);
    exp_t e;
    dir_in = din;
    if (exp !== exp_cur) begin
      e.at   = cyc + LAT;
      e.dout = exp;
      for (int p = 0; p < 2; p++) e.chg[p] = (exp[4*p +: 4] != exp_cur[4*p +: 4]);
      sb.push_back(e);
      exp_cur = exp;
    end
  endtask

  task automatic do_reset();
    #2 I_RESETn = 1'b0;
    #1;
    check8("async_reset_dir_out", dir_out, 8'h00);
    check8("async_reset_dir_chg", {6'd0, dir_chg}, 8'h00);
    step(3);
    I_RESETn = 1'b1;
    exp_cur  = 8'h00;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (I_RESETn && dir_chg != 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chg: cycle %0d dir_chg %b dir_out %h, nothing expected",
                   cyc, dir_chg, dir_out);
        end else begin
          e = sb.pop_front();
          checks += 3;
          if (cyc != e.at) begin
            errors++;
            $display("FAIL chg_cycle: got %0d expected %0d", cyc, e.at);
          end
          if (dir_out !== e.dout) begin
            errors++;
            $display("FAIL dir_out: got %h expected %h (cycle %0d)", dir_out, e.dout, cyc);
          end
          if (dir_chg !== e.chg) begin
            errors++;
            $display("FAIL dir_chg: got %b expected %b (cycle %0d)", dir_chg, e.chg, cyc);
          end
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_cur   = 8'h00;
    I_RESETn  = 1'b0;
    dir_in    = 8'h00;
    socd_mode = 2'b00;
    way4      = 1'b0;
    fork
      monitor();
    join_none

    step(3);
    check8("reset_dir_out", dir_out, 8'h00);
    check8("reset_dir_chg", {6'd0, dir_chg}, 8'h00);
    I_RESETn = 1'b1;
    step(5);
    check8("idle_dir_out", dir_out, 8'h00);

    // Last-wins: L, then R 10 cycles later, release R, release L
    apply(8'h02, 8'h02); step(10);
    apply(8'h03, 8'h01); step(30);
    apply(8'h02, 8'h02); step(30);
    apply(8'h00, 8'h00); step(30);

    // Simultaneous U+D in each mode
    apply(8'h0C, 8'h08); step(30);
    apply(8'h00, 8'h00); step(30);
    socd_mode = 2'b10;
    apply(8'h0C, 8'h08); step(30);
    apply(8'h00, 8'h00); step(30);
    socd_mode = 2'b01;
    apply(8'h0C, 8'h00); step(30);
    apply(8'h00, 8'h00); step(30);
    socd_mode = 2'b11;
    apply(8'h0C, 8'h0C); step(30);
    apply(8'h00, 8'h00); step(30);

    // First-wins: D held, U pressed later keeps D; releasing D yields U
    socd_mode = 2'b10;
    apply(8'h04, 8'h04); step(5);
    apply(8'h0C, 8'h04); step(30);
    apply(8'h08, 8'h08); step(30);
    apply(8'h00, 8'h00); step(30);

    // Player 1 independent: L+R tie goes to L, then P0 U joins, then both release
    socd_mode = 2'b00;
    apply(8'h30, 8'h20); step(30);
    apply(8'h38, 8'h28); step(30);
    apply(8'h00, 8'h00); step(30);

    // 4-way: R then U -> U; release U -> R; U then R -> R
    way4 = 1'b1;
    step(2);
    apply(8'h01, 8'h01); step(4);
    apply(8'h09, 8'h08); step(30);
    apply(8'h01, 8'h01); step(30);
    apply(8'h00, 8'h00); step(30);
    apply(8'h08, 8'h08); step(4);
    apply(8'h09, 8'h01); step(30);
    apply(8'h00, 8'h00); step(30);
    // After reset, simultaneous U+R keeps the reset axis (vertical)
    do_reset();
    apply(8'h09, 8'h08); step(30);
    apply(8'h00, 8'h00); step(30);
    way4 = 1'b0;
    step(2);
    apply(8'h09, 8'h09); step(30);
    apply(8'h00, 8'h00); step(30);

`ifdef JOY_DEBOUNCE_EN
    // Short glitch is rejected; 20-cycle press passes
    apply(8'h01, 8'h00); step(10);
    apply(8'h00, 8'h00); step(40);
    apply(8'h01, 8'h01); step(20);
    apply(8'h00, 8'h00); step(40);
`endif

    // Reset while U held, then U returns after the pipeline latency
    apply(8'h08, 8'h08); step(LAT + 10);
    do_reset();
    apply(8'h08, 8'h08); step(LAT + 10);
    apply(8'h00, 8'h00); step(LAT + 5);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected updates never seen", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
